// File: rtl/uart_pkg.sv
// UART shared definitions: parity selects, stop-bit selects and framer states.
// Shared between the TX framer and the RX block.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;
  localparam logic [1:0] PAR_MARK = 2'b11;

  localparam logic STOP_1 = 1'b0;
  localparam logic STOP_2 = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP
  } uart_state_e;

endpackage

// File: rtl/uart_parity_gen.sv
// Combinational parity bit over the low 'len' bits of a character.
// Also used on the RX side to check received parity.
module uart_parity_gen
  import uart_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] data,
  input  logic [3:0]   len,
  input  logic [1:0]   parity_type,
  output logic         parity
);

  logic ones_odd;

  // XOR-reduce the active bits, then map to the selected parity rule
  always_comb begin
    ones_odd = 1'b0;
    parity   = 1'b0;
    for (int unsigned i = 0; i < W; i++) begin
      if (i < 32'(len)) ones_odd = ones_odd ^ data[i];
    end
    case (parity_type)
      PAR_ODD:  parity = ~ones_odd;
      PAR_EVEN: parity = ones_odd;
      PAR_MARK: parity = 1'b1;
      default:  parity = 1'b0;
    endcase
  end

endmodule

// File: rtl/uart_tx_framer_ser.sv
// UART transmit framer/serialiser: latches a character on send&&ready and
// shifts start, data (LSB first), optional parity and stop bits out on tx,
// one bit per baud_tick. Accepts the next character during the last stop bit.
module uart_tx_framer_ser
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W_MAX = 8,
  parameter int unsigned MIN_DATA_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  baud_tick,
  input  logic [DATA_W_MAX-1:0] data_in,
  input  logic [3:0]            data_len,
  input  logic [1:0]            parity_type,
  input  logic                  stop_bits,
  input  logic                  send,
  output logic                  ready,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int unsigned CW      = $clog2(DATA_W_MAX + 1);
  localparam logic [3:0]  LEN_MIN = 4'(MIN_DATA_W);
  localparam logic [3:0]  LEN_MAX = 4'(DATA_W_MAX);

  uart_state_e           state_q;
  logic [DATA_W_MAX-1:0] shift_q;
  logic [CW-1:0]         len_q;
  logic [CW-1:0]         bit_cnt_q;
  logic                  par_en_q;
  logic                  par_bit_q;
  logic                  stop_sel_q;
  logic                  stop_cnt_q;
  logic                  pend_q;
  logic                  tx_q;
  logic                  done_q;

  logic [3:0] len_c;
  logic       par_c;
  logic       accept;

  // Clamp requested character length into the supported range
  always_comb begin
    len_c = data_len;
    if (data_len < LEN_MIN)      len_c = LEN_MIN;
    else if (data_len > LEN_MAX) len_c = LEN_MAX;
  end

  uart_parity_gen #(.W(DATA_W_MAX)) u_parity (
    .data        (data_in),
    .len         (len_c),
    .parity_type (parity_type),
    .parity      (par_c)
  );

  // Ready in IDLE, or in the final stop period while no frame is queued yet
  assign ready  = (state_q == ST_IDLE) ||
                  ((state_q == ST_STOP) && !stop_cnt_q && !pend_q);
  assign accept = send && ready;
  assign busy   = (state_q != ST_IDLE);
  assign tx     = tx_q;
  assign tx_done = done_q;

  // Frame FSM, bit/stop counters, shift register and registered line outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      len_q      <= '0;
      bit_cnt_q  <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop_sel_q <= STOP_1;
      stop_cnt_q <= 1'b0;
      pend_q     <= 1'b0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // Accept only happens in IDLE or the last stop bit, when shift_q is free
      if (accept) begin
        shift_q    <= data_in;
        len_q      <= CW'(len_c);
        par_en_q   <= (parity_type != PAR_NONE);
        par_bit_q  <= par_c;
        stop_sel_q <= stop_bits;
      end
      case (state_q)
        ST_IDLE: begin
          if (accept) state_q <= ST_ARMED;
        end
        ST_ARMED: begin
          if (baud_tick) begin
            state_q <= ST_START;
            tx_q    <= 1'b0;
          end
        end
        ST_START: begin
          if (baud_tick) begin
            state_q   <= ST_DATA;
            bit_cnt_q <= '0;
            tx_q      <= shift_q[0];
          end
        end
        ST_DATA: begin
          if (baud_tick) begin
            if (bit_cnt_q == len_q - CW'(1)) begin
              if (par_en_q) begin
                state_q <= ST_PAR;
                tx_q    <= par_bit_q;
              end else begin
                state_q    <= ST_STOP;
                tx_q       <= 1'b1;
                stop_cnt_q <= (stop_sel_q == STOP_2);
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + CW'(1);
              shift_q   <= shift_q >> 1;
              tx_q      <= shift_q[1];
            end
          end
        end
        ST_PAR: begin
          if (baud_tick) begin
            state_q    <= ST_STOP;
            tx_q       <= 1'b1;
            stop_cnt_q <= (stop_sel_q == STOP_2);
          end
        end
        ST_STOP: begin
          if (baud_tick) begin
            if (stop_cnt_q) begin
              stop_cnt_q <= 1'b0;
            end else begin
              done_q <= 1'b1;
              pend_q <= 1'b0;
              // Queued frame starts with no idle gap; an accept landing on
              // the ending tick itself waits for the next tick like IDLE does
              if (pend_q) begin
                state_q <= ST_START;
                tx_q    <= 1'b0;
              end else if (accept) begin
                state_q <= ST_ARMED;
              end else begin
                state_q <= ST_IDLE;
              end
            end
          end else if (accept) begin
            pend_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_framer_ser.sv
// Self-checking bench for uart_tx_framer_ser: randomized frames compared
// against a bit-list model of the UART frame format.
module tb_uart_tx_framer_ser;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       baud_tick;
  logic [7:0] data_in;
  logic [3:0] data_len;
  logic [1:0] parity_type;
  logic       stop_bits;
  logic       send;
  logic       ready, tx, busy, tx_done;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;
  int acc_cnt  = 0;
  int acc_limit = 1 << 30;
  bit line_q[$];
  bit exp_q[$];

  always #5 clk = ~clk;

  uart_tx_framer_ser #(.DATA_W_MAX(8), .MIN_DATA_W(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .baud_tick   (baud_tick),
    .data_in     (data_in),
    .data_len    (data_len),
    .parity_type (parity_type),
    .stop_bits   (stop_bits),
    .send        (send),
    .ready       (ready),
    .tx          (tx),
    .busy        (busy),
    .tx_done     (tx_done)
  );

  // Line monitor: tx value per tick period, tx_done cycles, accepted requests
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (baud_tick) line_q.push_back(tx);
      if (tx_done) done_cnt++;
      if (send && ready) acc_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference frame: start, clamped data LSB first, parity by ones count, stops
  function automatic void model_frame(input logic [7:0] d, input logic [3:0] dl,
                                      input logic [1:0] pt, input logic sb);
    int L;
    int ones;
    L = (dl < 5) ? 5 : ((dl > 8) ? 8 : int'(dl));
    ones = 0;
    exp_q.push_back(1'b0);
    for (int i = 0; i < L; i++) begin
      exp_q.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (pt == 2'b01) exp_q.push_back(ones % 2 == 0);
    if (pt == 2'b10) exp_q.push_back(ones % 2 == 1);
    if (pt == 2'b11) exp_q.push_back(1'b1);
    exp_q.push_back(1'b1);
    if (sb) exp_q.push_back(1'b1);
  endfunction

  function automatic logic [31:0] pack(input bit q[$]);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < q.size() && i < 32; i++) v[i] = q[i];
    return v;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
    if (send && acc_cnt >= acc_limit) send = 1'b0;
  endtask

  task automatic do_tick();
    baud_tick = 1'b1;
    cyc();
    baud_tick = 1'b0;
    repeat ($urandom_range(1, 3)) cyc();
  endtask

  task automatic check_line(input string tag);
    chk({tag, "/len"}, 32'(line_q.size()), 32'(exp_q.size()));
    chk({tag, "/bits"}, pack(line_q), pack(exp_q));
  endtask

  task automatic send_frame(input logic [7:0] d, input logic [3:0] dl, input logic [1:0] pt,
                            input logic sb, input bit tick_acc, input bit intrude,
                            input string tag);
    int d0;
    int w;
    exp_q.delete();
    if (tick_acc) exp_q.push_back(1'b1);
    exp_q.push_back(1'b1);
    model_frame(d, dl, pt, sb);
    w = 0;
    while (!ready && w < 50) begin
      cyc();
      w++;
    end
    chk({tag, "/ready_idle"}, 32'(ready), 32'd1);
    line_q.delete();
    d0 = done_cnt;
    data_in = d; data_len = dl; parity_type = pt; stop_bits = sb;
    send = 1'b1;
    baud_tick = tick_acc;
    cyc();
    send = 1'b0;
    baud_tick = 1'b0;
    chk({tag, "/ready_after_acc"}, 32'(ready), 32'd0);
    chk({tag, "/busy"}, 32'(busy), 32'd1);
    data_in = 8'($urandom); data_len = 4'($urandom);
    parity_type = 2'($urandom); stop_bits = 1'($urandom);
    repeat ($urandom_range(0, 2)) cyc();
    for (int k = 0; k < 20 && done_cnt == d0; k++) begin
      do_tick();
      if (intrude && k == 3) begin
        chk({tag, "/ready_mid"}, 32'(ready), 32'd0);
        data_in = ~d;
        send = 1'b1;
        cyc();
        send = 1'b0;
      end
    end
    chk({tag, "/done"}, 32'(done_cnt - d0), 32'd1);
    check_line(tag);
    chk({tag, "/ready_end"}, 32'(ready), 32'd1);
    chk({tag, "/busy_end"}, 32'(busy), 32'd0);
    chk({tag, "/tx_idle"}, 32'(tx), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d0;
    int a0;
    rst_n = 1'b0; baud_tick = 1'b0; send = 1'b0;
    data_in = '0; data_len = '0; parity_type = '0; stop_bits = 1'b0;
    repeat (3) cyc();
    chk("reset/tx", 32'(tx), 32'd1);
    chk("reset/ready", 32'(ready), 32'd1);
    chk("reset/busy", 32'(busy), 32'd0);
    chk("reset/tx_done", 32'(tx_done), 32'd0);
    rst_n = 1'b1;
    cyc();

    // Directed frames
    send_frame(8'hA5, 4'd8, 2'b00, 1'b0, 1'b0, 1'b0, "8N1_A5");
    send_frame(8'h55, 4'd7, 2'b10, 1'b1, 1'b0, 1'b0, "7E2_55");
    send_frame(8'hAA, 4'd8, 2'b01, 1'b0, 1'b0, 1'b0, "8O1_AA");
    send_frame(8'hAA, 4'd8, 2'b11, 1'b0, 1'b0, 1'b0, "8M1_AA");
    send_frame(8'hC3, 4'd3, 2'b00, 1'b0, 1'b0, 1'b0, "len3");
    send_frame(8'h3C, 4'd0, 2'b01, 1'b1, 1'b0, 1'b0, "len0");
    send_frame(8'h96, 4'd12, 2'b10, 1'b1, 1'b0, 1'b0, "len12");
    send_frame(8'h5A, 4'd8, 2'b00, 1'b0, 1'b0, 1'b1, "intrude");
    send_frame(8'h81, 4'd8, 2'b00, 1'b0, 1'b1, 1'b0, "tick_on_acc");

    // Back-to-back with send held: second frame follows the first stop bit
    exp_q.delete();
    exp_q.push_back(1'b1);
    model_frame(8'h01, 4'd8, 2'b00, 1'b0);
    model_frame(8'h80, 4'd8, 2'b00, 1'b0);
    line_q.delete();
    d0 = done_cnt;
    a0 = acc_cnt;
    acc_limit = acc_cnt + 2;
    data_in = 8'h01; data_len = 4'd8; parity_type = 2'b00; stop_bits = 1'b0;
    send = 1'b1;
    cyc();
    data_in = 8'h80;
    for (int k = 0; k < 30 && (done_cnt - d0) < 2; k++) do_tick();
    acc_limit = 1 << 30;
    send = 1'b0;
    chk("b2b/accepts", 32'(acc_cnt - a0), 32'd2);
    chk("b2b/done", 32'(done_cnt - d0), 32'd2);
    check_line("b2b");
    chk("b2b/ready_end", 32'(ready), 32'd1);

    // Reset in the middle of the data bits
    data_in = 8'hF0; data_len = 4'd8; parity_type = 2'b01; stop_bits = 1'b1;
    send = 1'b1;
    cyc();
    send = 1'b0;
    repeat (5) do_tick();
    d0 = done_cnt;
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    chk("midrst/tx", 32'(tx), 32'd1);
    chk("midrst/ready", 32'(ready), 32'd1);
    chk("midrst/busy", 32'(busy), 32'd0);
    chk("midrst/tx_done", 32'(tx_done), 32'd0);
    line_q.delete();
    repeat (12) do_tick();
    chk("midrst/no_done", 32'(done_cnt - d0), 32'd0);
    chk("midrst/line_high", pack(line_q), 32'h0000_0FFF);
    send_frame(8'h3A, 4'd8, 2'b10, 1'b0, 1'b0, 1'b0, "after_rst");

    // Randomized frames
    for (int n = 0; n < 40; n++) begin
      send_frame(8'($urandom), 4'($urandom), 2'($urandom), 1'($urandom),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                 $sformatf("rnd%0d", n));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
